// File: rtl/sprite_anim_sequencer.sv
// Player sprite animation sequencer.
// Each toggle of change_frame (in either direction) is one animation tick.
// The ticks step the IDLE/WALK/JUMP motion FSM and its frame index. The
// current VGA pixel is mapped onto a word address in the packed sprite ROM,
// with optional horizontal mirroring.
// ROM layout, one SPRITE_W*SPRITE_H row-major slot per frame:
//   slots 0..1                 IDLE frames
//   slots 2..WALK_FRAMES+1     WALK frames
//   slot  WALK_FRAMES+2        JUMP frame
// There is no valid/ready handshake. Every input is a level sampled on each
// Clk. sprite_on and sprite_rom_addr follow the pixel inputs by one Clk.
module sprite_anim_sequencer #(
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int WALK_FRAMES = 4,
  parameter int JUMP_TICKS  = 6,
  parameter int ADDR_W      = 14
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              change_frame,
  input  logic              move_left,
  input  logic              move_right,
  input  logic              jump_req,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] sprite_rom_addr,
  output logic              sprite_on,
  output logic [1:0]        anim_state,
  output logic [2:0]        anim_frame,
  output logic              facing_left
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WALK = 2'b01;
  localparam logic [1:0] ST_JUMP = 2'b10;

  localparam int ROW_SH  = $clog2(SPRITE_W);
  localparam int SLOT_SH = $clog2(SPRITE_W * SPRITE_H);

  logic              change_frame_q;
  logic [1:0]        state_q, state_d;
  logic [2:0]        frame_q, frame_d;
  logic              facing_q, facing_d;
  logic [3:0]        jcnt_q, jcnt_d;
  logic              on_q, on_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic        tick;
  logic        moving;
  logic [10:0] dx, dy;
  logic        in_box;
  logic [9:0]  col;
  logic [3:0]  slot;

  assign tick   = change_frame ^ change_frame_q;
  assign moving = move_left ^ move_right;

  // Motion FSM, jump duration counter and frame index
  always_comb begin
    state_d = state_q;
    jcnt_d  = jcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (jump_req)    state_d = ST_JUMP;
        else if (moving) state_d = ST_WALK;
      end
      ST_WALK: begin
        if (jump_req)     state_d = ST_JUMP;
        else if (!moving) state_d = ST_IDLE;
      end
      ST_JUMP: begin
        // A jump always runs its full length; jump_req is not a retrigger.
        if (tick) begin
          if (jcnt_q == 4'(JUMP_TICKS - 1)) begin
            state_d = moving ? ST_WALK : ST_IDLE;
            jcnt_d  = 4'd0;
          end else begin
            jcnt_d = jcnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        jcnt_d  = 4'd0;
      end
    endcase

    // A state change restarts the frame index, even if a tick arrives too.
    frame_d = frame_q;
    if (state_d != state_q) begin
      frame_d = 3'd0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: frame_d = (frame_q == 3'd0) ? 3'd1 : 3'd0;
        ST_WALK: frame_d = (frame_q == 3'(WALK_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
        default: frame_d = 3'd0;
      endcase
    end

    facing_d = facing_q;
    if (move_left && !move_right)      facing_d = 1'b1;
    else if (move_right && !move_left) facing_d = 1'b0;
  end

  // Pixel to ROM word address, using the animation state of this cycle
  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, SpriteX};
    dy     = {1'b0, DrawY} - {1'b0, SpriteY};
    in_box = !dx[10] && (dx[9:0] < 10'(SPRITE_W)) &&
             !dy[10] && (dy[9:0] < 10'(SPRITE_H));
    col    = facing_q ? (10'(SPRITE_W - 1) - dx[9:0]) : dx[9:0];
    case (state_q)
      ST_IDLE: slot = {1'b0, frame_q};
      ST_WALK: slot = 4'd2 + {1'b0, frame_q};
      ST_JUMP: slot = 4'(2 + WALK_FRAMES);
      default: slot = 4'd0;
    endcase
    on_d   = in_box;
    addr_d = '0;
    if (in_box) begin
      addr_d = (ADDR_W'(slot) << SLOT_SH) + (ADDR_W'(dy[9:0]) << ROW_SH) + ADDR_W'(col);
    end
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      change_frame_q <= 1'b0;
      state_q        <= ST_IDLE;
      frame_q        <= 3'd0;
      facing_q       <= 1'b0;
      jcnt_q         <= 4'd0;
      on_q           <= 1'b0;
      addr_q         <= '0;
    end else begin
      change_frame_q <= change_frame;
      state_q        <= state_d;
      frame_q        <= frame_d;
      facing_q       <= facing_d;
      jcnt_q         <= jcnt_d;
      on_q           <= on_d;
      addr_q         <= addr_d;
    end
  end

  assign anim_state      = state_q;
  assign anim_frame      = frame_q;
  assign facing_left     = facing_q;
  assign sprite_on       = on_q;
  assign sprite_rom_addr = addr_q;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Testbench for sprite_anim_sequencer.
// A directed sequence with literal expected values comes first. A randomized
// run follows. On every Clk a tick-counting reference model predicts all of
// the outputs.
module tb_sprite_anim_sequencer;

  localparam int SW = 32;
  localparam int SH = 32;
  localparam int WF = 4;
  localparam int JT = 6;
  localparam int AW = 14;
  localparam int W  = 2 + 3 + 1 + 1 + AW;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          change_frame = 1'b0;
  logic          move_left = 1'b0;
  logic          move_right = 1'b0;
  logic          jump_req = 1'b0;
  logic [9:0]    SpriteX = '0;
  logic [9:0]    SpriteY = '0;
  logic [9:0]    DrawX = '0;
  logic [9:0]    DrawY = '0;
  logic [AW-1:0] sprite_rom_addr;
  logic          sprite_on;
  logic [1:0]    anim_state;
  logic [2:0]    anim_frame;
  logic          facing_left;

  sprite_anim_sequencer #(
    .SPRITE_W(SW), .SPRITE_H(SH), .WALK_FRAMES(WF), .JUMP_TICKS(JT), .ADDR_W(AW)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .change_frame(change_frame),
    .move_left(move_left), .move_right(move_right), .jump_req(jump_req),
    .SpriteX(SpriteX), .SpriteY(SpriteY), .DrawX(DrawX), .DrawY(DrawY),
    .sprite_rom_addr(sprite_rom_addr), .sprite_on(sprite_on),
    .anim_state(anim_state), .anim_frame(anim_frame), .facing_left(facing_left)
  );

  // Clock block
  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model. A state is 0 idle, 1 walk or 2 jump. The frame comes
  // from the count of ticks seen since the state was entered. A jump counts
  // down the ticks it has left.
  int m_state, m_ticks, m_facing, m_cf_prev, m_jump_left, m_on, m_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_frame();
    if (m_state == 0) return m_ticks % 2;
    if (m_state == 1) return m_ticks % WF;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ticks = 0; m_facing = 0; m_cf_prev = 0;
    m_jump_left = 0; m_on = 0; m_addr = 0;
  endtask

  // Predicts the outputs after the next Clk edge from the current inputs.
  task automatic model_predict();
    int dx, dy, slot, col, nxt;
    bit tk, mv;
    tk = (int'(change_frame) != m_cf_prev);
    mv = move_left != move_right;
    dx = int'(DrawX) - int'(SpriteX);
    dy = int'(DrawY) - int'(SpriteY);
    m_on = (dx >= 0 && dx < SW && dy >= 0 && dy < SH) ? 1 : 0;
    slot = (m_state == 0) ? m_frame() : (m_state == 1) ? 2 + m_frame() : 2 + WF;
    col  = m_facing ? SW - 1 - dx : dx;
    m_addr = m_on ? (slot * SW * SH + dy * SW + col) % (1 << AW) : 0;
    nxt = m_state;
    if (m_state == 2) begin
      if (tk) begin
        m_jump_left--;
        if (m_jump_left == 0) nxt = mv ? 1 : 0;
      end
    end else if (jump_req) begin
      nxt = 2;
      m_jump_left = JT;
    end else begin
      nxt = mv ? 1 : 0;
    end
    if (nxt != m_state) m_ticks = 0;
    else if (tk) m_ticks++;
    m_state = nxt;
    if (move_left && !move_right) m_facing = 1;
    else if (move_right && !move_left) m_facing = 0;
    m_cf_prev = int'(change_frame);
    exp_q.push_back({2'(m_state), 3'(m_frame()), 1'(m_facing), 1'(m_on), AW'(m_addr)});
  endtask

  // Driver: predict, clock once, then score the outputs 1 time unit after the edge.
  task automatic step();
    logic [W-1:0] e;
    model_predict();
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check("anim_state", 32'(anim_state), 32'(e[W-1 -: 2]));
      check("anim_frame", 32'(anim_frame), 32'(e[W-3 -: 3]));
      check("facing_left", 32'(facing_left), 32'(e[AW+1]));
      check("sprite_on", 32'(sprite_on), 32'(e[AW]));
      check("sprite_rom_addr", 32'(sprite_rom_addr), 32'(e[AW-1:0]));
    end
  endtask

  initial begin
    // Reset block
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", 32'(anim_state), 0);
    check("reset_frame", 32'(anim_frame), 0);
    check("reset_on", 32'(sprite_on), 0);
    check("reset_addr", 32'(sprite_rom_addr), 0);
    Reset_n = 1'b1;

    // Idle: five toggles. Holding the level in between must not add ticks.
    for (int i = 0; i < 5; i++) begin
      change_frame = ~change_frame;
      step();
      check("idle_frame", 32'(anim_frame), (i % 2 == 0) ? 1 : 0);
      check("idle_state", 32'(anim_state), 0);
      step();
      step();
    end

    // Walk right
    move_right = 1'b1;
    step();
    check("walk_enter_state", 32'(anim_state), 1);
    check("walk_enter_frame", 32'(anim_frame), 0);
    for (int i = 0; i < 6; i++) begin
      change_frame = ~change_frame;
      step();
      check("walk_frame", 32'(anim_frame), (i + 1) % 4);
      check("walk_facing", 32'(facing_left), 0);
      step();
    end

    // Pixel mapping at walk frame 2
    SpriteX = 10'd100; SpriteY = 10'd50; DrawX = 10'd105; DrawY = 10'd53;
    step();
    check("pix_on", 32'(sprite_on), 1);
    check("pix_addr_right", 32'(sprite_rom_addr), 4197);
    move_left = 1'b1; move_right = 1'b0;
    step();
    check("turn_facing", 32'(facing_left), 1);
    check("turn_state", 32'(anim_state), 1);
    step();
    check("pix_addr_left", 32'(sprite_rom_addr), 4218);
    DrawX = 10'd132;
    step();
    check("pix_out_on", 32'(sprite_on), 0);
    check("pix_out_addr", 32'(sprite_rom_addr), 0);

    // Jump from walk, with a re-asserted request mid-jump
    move_left = 1'b0; move_right = 1'b1; jump_req = 1'b1;
    step();
    jump_req = 1'b0;
    check("jump_state", 32'(anim_state), 2);
    check("jump_frame", 32'(anim_frame), 0);
    for (int i = 0; i < 6; i++) begin
      change_frame = ~change_frame;
      jump_req = (i == 2);
      step();
      jump_req = 1'b0;
      check("jump_len_state", 32'(anim_state), (i < 5) ? 2 : 1);
      check("jump_len_frame", 32'(anim_frame), 0);
      step();
    end

    // Idle at frame 1, then a tick and movement in the same cycle
    move_right = 1'b0;
    step();
    change_frame = ~change_frame;
    step();
    check("pre_race_frame", 32'(anim_frame), 1);
    change_frame = ~change_frame;
    move_right = 1'b1;
    step();
    check("race_state", 32'(anim_state), 1);
    check("race_frame", 32'(anim_frame), 0);

    // Asynchronous reset in the middle of a jump
    move_left = 1'b1; move_right = 1'b0; DrawX = 10'd105;
    step();
    jump_req = 1'b1;
    step();
    jump_req = 1'b0;
    change_frame = ~change_frame;
    step();
    #3 Reset_n = 1'b0;
    #1;
    check("areset_state", 32'(anim_state), 0);
    check("areset_frame", 32'(anim_frame), 0);
    check("areset_facing", 32'(facing_left), 0);
    check("areset_on", 32'(sprite_on), 0);
    check("areset_addr", 32'(sprite_rom_addr), 0);
    model_reset();
    @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) change_frame = ~change_frame;
      if ($urandom_range(0, 7) == 0) move_left  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) move_right = 1'($urandom_range(0, 1));
      jump_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        SpriteX = 10'($urandom_range(8, 600));
        SpriteY = 10'($urandom_range(8, 440));
      end
      if ($urandom_range(0, 1) == 0) begin
        DrawX = 10'($urandom_range(0, 639));
        DrawY = 10'($urandom_range(0, 479));
      end else begin
        DrawX = SpriteX + 10'($urandom_range(0, 40)) - 10'd4;
        DrawY = SpriteY + 10'($urandom_range(0, 40)) - 10'd4;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
